// File: rtl/cache_controller_if.sv
// Bundle of all signals between cache_controller and its neighbours.
//   cpu side   : cpu_addr, cpu_rd, cpu_wr -> stall
//   memory side: mem_rd, mem_wr, mem_addr -> mem_ready
//   cache side : cache_block_num, cache_byte_offset, cache_tag, cache_valid,
//                cache_we, cache_data_sel -> cache_out_tag, cache_out_valid
//   counters   : read_hits, read_misses
// modport master is the controller's view, slave is the environment's view.
interface cache_controller_if #(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_rd;
  logic                cpu_wr;
  logic                stall;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ready;
  logic [INDEX_W-1:0]  cache_block_num;
  logic [OFFSET_W-1:0] cache_byte_offset;
  logic [TAG_W-1:0]    cache_tag;
  logic                cache_valid;
  logic                cache_we;
  logic                cache_data_sel;
  logic [TAG_W-1:0]    cache_out_tag;
  logic                cache_out_valid;
  logic [CNT_W-1:0]    read_hits;
  logic [CNT_W-1:0]    read_misses;

  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, mem_ready, cache_out_tag, cache_out_valid,
    output stall, mem_rd, mem_wr, mem_addr, cache_block_num, cache_byte_offset,
           cache_tag, cache_valid, cache_we, cache_data_sel, read_hits, read_misses
  );

  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, mem_ready, cache_out_tag, cache_out_valid,
    input  stall, mem_rd, mem_wr, mem_addr, cache_block_num, cache_byte_offset,
           cache_tag, cache_valid, cache_we, cache_data_sel, read_hits, read_misses
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Decodes the CPU word address, detects hits from the cache tag/valid read
// path, stalls the CPU on misses, refills a block word by word from main
// memory and drives the cache write port.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - cache_controller_if.master (CPU, memory, cache and counter signals)
//
// state  | meaning
// IDLE   | accept CPU requests; read hits complete here with no wait state
// REFILL | fetch the missed block from memory, one word per mem_ready
// WRITE  | write-through of one word; cache updated only if it was a hit
module cache_controller #(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
) (
  input logic               CLK,
  input logic               RST,
  cache_controller_if.master bus
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WRITE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                wr_hit_q, wr_hit_d;
  logic                skip_hit_q, skip_hit_d;
  logic [CNT_W-1:0]    hits_q, hits_d;
  logic [CNT_W-1:0]    misses_q, misses_d;

  logic [ADDR_W-1:0]   cur_addr;
  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  cur_index;
  logic [OFFSET_W-1:0] cur_offset;
  logic                hit;

  // In IDLE the live CPU address drives the cache; otherwise the latched one.
  assign cur_addr   = (state_q == IDLE) ? bus.cpu_addr : req_addr_q;
  assign cur_tag    = cur_addr[ADDR_W-1 -: TAG_W];
  assign cur_index  = cur_addr[OFFSET_W +: INDEX_W];
  assign cur_offset = cur_addr[OFFSET_W-1:0];
  assign hit        = bus.cache_out_valid && (bus.cache_out_tag == cur_tag);

  assign bus.cache_block_num = cur_index;
  assign bus.cache_tag       = cur_tag;
  assign bus.cache_valid     = 1'b1;
  assign bus.read_hits       = hits_q;
  assign bus.read_misses     = misses_q;

  always_comb begin
    state_d               = state_q;
    req_addr_d            = req_addr_q;
    cnt_d                 = cnt_q;
    wr_hit_d              = wr_hit_q;
    skip_hit_d            = 1'b0;
    hits_d                = hits_q;
    misses_d              = misses_q;
    bus.stall             = 1'b0;
    bus.mem_rd            = 1'b0;
    bus.mem_wr            = 1'b0;
    bus.mem_addr          = req_addr_q;
    bus.cache_byte_offset = cur_offset;
    bus.cache_we          = 1'b0;
    bus.cache_data_sel    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_wr) begin
          bus.stall  = 1'b1;
          state_d    = WRITE;
          req_addr_d = bus.cpu_addr;
          wr_hit_d   = hit;
        end else if (bus.cpu_rd) begin
          if (hit) begin
            // The read that caused a refill hits again right after it; that
            // one was already counted as a miss.
            if (!skip_hit_q && !(&hits_q)) hits_d = hits_q + CNT_W'(1);
          end else begin
            bus.stall  = 1'b1;
            state_d    = REFILL;
            req_addr_d = bus.cpu_addr;
            cnt_d      = '0;
            if (!(&misses_q)) misses_d = misses_q + CNT_W'(1);
          end
        end
      end
      REFILL: begin
        bus.stall             = 1'b1;
        bus.mem_rd            = 1'b1;
        bus.mem_addr          = {cur_tag, cur_index, cnt_q};
        bus.cache_byte_offset = cnt_q;
        if (bus.mem_ready) begin
          bus.cache_we       = 1'b1;
          bus.cache_data_sel = 1'b1;
          cnt_d              = cnt_q + OFFSET_W'(1);
          if (&cnt_q) begin
            state_d    = IDLE;
            skip_hit_d = 1'b1;
          end
        end
      end
      WRITE: begin
        bus.mem_wr = 1'b1;
        bus.stall  = !bus.mem_ready;
        if (bus.mem_ready) begin
          bus.cache_we = wr_hit_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      wr_hit_q   <= 1'b0;
      skip_hit_q <= 1'b0;
      hits_q     <= '0;
      misses_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      wr_hit_q   <= wr_hit_d;
      skip_hit_q <= skip_hit_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache_memory stand-in, a memory
// responder with programmable latency, a bus monitor, and a block-level
// reference model of the cache contents and hit/miss counters.
module tb_cache_controller;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 2;
  localparam int CNT_W    = 4;   // narrow so saturation is reachable
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_controller_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) bus ();

  cache_controller #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int lat      = 3;
  int wait_cnt = 0;

  // cache_memory stand-in: per-block tag/valid, cleared by reset.
  logic [2:0] cm_tag   [32];
  logic       cm_valid [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cm_valid[i] <= 1'b0;
    end else if (bus.cache_we) begin
      cm_tag[bus.cache_block_num]   <= bus.cache_tag;
      cm_valid[bus.cache_block_num] <= bus.cache_valid;
    end
  end
  assign bus.cache_out_tag   = cm_tag[bus.cache_block_num];
  assign bus.cache_out_valid = cm_valid[bus.cache_block_num];

  // Memory: pulses mem_ready in the lat-th cycle of a pending request, then
  // idles one cycle before counting again. A read miss therefore stalls
  // 1 (IDLE) + lat + 3*(lat+1) = 4*lat+4 cycles; a write stalls lat cycles.
  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bus.mem_ready = 1'b0; wait_cnt = 0;
      end else if (bus.mem_ready) begin
        bus.mem_ready = 1'b0; wait_cnt = 0;
      end else if (bus.mem_rd || bus.mem_wr) begin
        wait_cnt++;
        if (wait_cnt >= lat) bus.mem_ready = 1'b1;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  typedef struct packed {
    logic [1:0] off;
    logic [4:0] blk;
    logic [2:0] tg;
    logic       vld;
    logic       sel;
  } we_t;

  logic [9:0] rd_log [$];
  logic [9:0] wr_log [$];
  we_t        we_log [$];
  int         we_orphan = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_ready && bus.mem_rd) rd_log.push_back(bus.mem_addr);
      if (bus.mem_ready && bus.mem_wr) wr_log.push_back(bus.mem_addr);
      if (bus.cache_we) begin
        we_log.push_back({bus.cache_byte_offset, bus.cache_block_num, bus.cache_tag,
                          bus.cache_valid, bus.cache_data_sel});
        if (!bus.mem_ready) we_orphan++;
      end
    end
  end

  // Reference model: which tag each block holds, and the expected counters.
  logic [2:0] ref_tag   [32];
  bit         ref_valid [32];
  int         ref_hits, ref_misses;

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    ref_clear();
  endtask

  // Drive one CPU request, hold it until stall is low at a negedge, release
  // it after the accepting edge. stalled = cycles seen with stall high.
  task automatic cpu_op(input bit rd, input bit wr, input logic [9:0] addr,
                        output int stalled, output bit timeout);
    rd_log.delete(); wr_log.delete(); we_log.delete();
    stalled = 0; timeout = 1'b0;
    @(posedge clk); #1;
    bus.cpu_addr = addr; bus.cpu_rd = rd; bus.cpu_wr = wr;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      stalled++;
      if (stalled > 200) begin timeout = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_req got rd=%b wr=%b exp 0/0", bus.mem_rd, bus.mem_wr); end
    checks++; if (bus.cache_we !== 1'b0) begin failures++; $display("FAIL reset_cache_we got=%b exp=0", bus.cache_we); end
    checks++; if (bus.read_hits !== '0 || bus.read_misses !== '0) begin failures++; $display("FAIL reset_counters got hits=%0d misses=%0d exp 0/0", bus.read_hits, bus.read_misses); end
    rst = 1'b0;
  endtask

  task automatic test_read_miss();
    int st; bit to;
    lat = 3;
    cpu_op(1'b1, 1'b0, 10'h100, st, to);
    checks++; if (to) begin failures++; $display("FAIL miss_timeout stall never dropped"); end
    checks++;
    if (rd_log.size() != 4) begin failures++; $display("FAIL miss_rd_count got=%0d exp=4", rd_log.size()); end
    else for (int i = 0; i < 4; i++)
      if (rd_log[i] !== 10'(10'h100 + i)) begin failures++; $display("FAIL miss_rd_addr[%0d] got=%h exp=%h", i, rd_log[i], 10'h100 + i); end
    checks++;
    if (we_log.size() != 4) begin failures++; $display("FAIL miss_we_count got=%0d exp=4", we_log.size()); end
    else for (int i = 0; i < 4; i++)
      if (we_log[i] !== {2'(i), 5'd0, 3'd2, 1'b1, 1'b1}) begin failures++; $display("FAIL miss_we[%0d] got=%h exp=%h", i, we_log[i], {2'(i), 5'd0, 3'd2, 1'b1, 1'b1}); end
    checks++; if (st != 4 * lat + 4) begin failures++; $display("FAIL miss_stall_cycles got=%0d exp=%0d", st, 4 * lat + 4); end
    checks++; if (bus.read_misses !== 4'd1 || bus.read_hits !== 4'd0) begin failures++; $display("FAIL miss_counters got hits=%0d misses=%0d exp 0/1", bus.read_hits, bus.read_misses); end
  endtask

  task automatic test_read_hit();
    int st; bit to;
    cpu_op(1'b1, 1'b0, 10'h102, st, to);
    checks++; if (st != 0 || to) begin failures++; $display("FAIL hit_stall got=%0d exp=0", st); end
    checks++; if (rd_log.size() != 0 || we_log.size() != 0) begin failures++; $display("FAIL hit_traffic got rd=%0d we=%0d exp 0/0", rd_log.size(), we_log.size()); end
    checks++; if (bus.read_hits !== 4'd1 || bus.read_misses !== 4'd1) begin failures++; $display("FAIL hit_counters got hits=%0d misses=%0d exp 1/1", bus.read_hits, bus.read_misses); end
  endtask

  task automatic test_write_hit();
    int st; bit to;
    lat = 3;
    cpu_op(1'b0, 1'b1, 10'h101, st, to);
    checks++; if (wr_log.size() != 1 || rd_log.size() != 0) begin failures++; $display("FAIL wrhit_mem got wr=%0d rd=%0d exp 1/0", wr_log.size(), rd_log.size()); end
    else if (wr_log[0] !== 10'h101) begin failures++; $display("FAIL wrhit_addr got=%h exp=101", wr_log[0]); end
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL wrhit_we_count got=%0d exp=1", we_log.size()); end
    else if (we_log[0] !== {2'd1, 5'd0, 3'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL wrhit_we got=%h exp=%h", we_log[0], {2'd1, 5'd0, 3'd2, 1'b1, 1'b0}); end
    checks++; if (st != lat || to) begin failures++; $display("FAIL wrhit_stall_cycles got=%0d exp=%0d", st, lat); end
    checks++; if (bus.read_hits !== 4'd1 || bus.read_misses !== 4'd1) begin failures++; $display("FAIL wrhit_counters got hits=%0d misses=%0d exp 1/1", bus.read_hits, bus.read_misses); end
  endtask

  task automatic test_write_miss();
    int st; bit to;
    lat = 2;
    cpu_op(1'b0, 1'b1, 10'h300, st, to);
    checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL wrmiss_mem got wr=%0d exp 1", wr_log.size()); end
    else if (wr_log[0] !== 10'h300) begin failures++; $display("FAIL wrmiss_addr got=%h exp=300", wr_log[0]); end
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL wrmiss_we got=%0d exp=0", we_log.size()); end
    checks++; if (st != lat || to) begin failures++; $display("FAIL wrmiss_stall_cycles got=%0d exp=%0d", st, lat); end
    checks++; if (bus.read_hits !== 4'd1 || bus.read_misses !== 4'd1) begin failures++; $display("FAIL wrmiss_counters got hits=%0d misses=%0d exp 1/1", bus.read_hits, bus.read_misses); end
  endtask

  task automatic test_conflict();
    int st; bit to;
    lat = 2;
    cpu_op(1'b1, 1'b0, 10'h180, st, to);
    checks++;
    if (rd_log.size() != 4) begin failures++; $display("FAIL conflict_rd_count got=%0d exp=4", rd_log.size()); end
    else for (int i = 0; i < 4; i++)
      if (rd_log[i] !== 10'(10'h180 + i)) begin failures++; $display("FAIL conflict_rd_addr[%0d] got=%h exp=%h", i, rd_log[i], 10'h180 + i); end
    checks++;
    if (we_log.size() != 4) begin failures++; $display("FAIL conflict_we_count got=%0d exp=4", we_log.size()); end
    else for (int i = 0; i < 4; i++)
      if (we_log[i] !== {2'(i), 5'd0, 3'd3, 1'b1, 1'b1}) begin failures++; $display("FAIL conflict_we[%0d] got=%h exp=%h", i, we_log[i], {2'(i), 5'd0, 3'd3, 1'b1, 1'b1}); end
    checks++; if (st != 4 * lat + 4 || to) begin failures++; $display("FAIL conflict_stall_cycles got=%0d exp=%0d", st, 4 * lat + 4); end
    checks++; if (bus.read_misses !== 4'd2) begin failures++; $display("FAIL conflict_misses got=%0d exp=2", bus.read_misses); end
  endtask

  // Read 0x100 (now evicted by 0x180), reset after the 2nd refill word.
  task automatic test_reset_mid_refill();
    int st; bit to; int guard;
    lat = 2;
    rd_log.delete(); wr_log.delete(); we_log.delete();
    @(posedge clk); #1;
    bus.cpu_addr = 10'h100; bus.cpu_rd = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk); #1;
      if (we_log.size() >= 2) break;
      guard++;
      if (guard > 100) break;
    end
    checks++; if (guard > 100) begin failures++; $display("FAIL rstmid_timeout we_count=%0d exp>=2", we_log.size()); end
    checks++; if (bus.read_misses !== 4'd3) begin failures++; $display("FAIL rstmid_miss_counted got=%0d exp=3", bus.read_misses); end
    checks++; if (rd_log.size() != 2) begin failures++; $display("FAIL rstmid_rd_count got=%0d exp=2", rd_log.size()); end
    else if (rd_log[0] !== 10'h100 || rd_log[1] !== 10'h101) begin failures++; $display("FAIL rstmid_rd_addr got=%h,%h exp=100,101", rd_log[0], rd_log[1]); end
    @(posedge clk); #1;
    rst = 1'b1; bus.cpu_rd = 1'b0;
    #1;
    checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL rstmid_mem_rd got=%b exp=0", bus.mem_rd); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.read_misses !== 4'd0) begin failures++; $display("FAIL rstmid_counter got=%0d exp=0", bus.read_misses); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    cpu_op(1'b1, 1'b0, 10'h100, st, to);
    checks++;
    if (rd_log.size() != 4) begin failures++; $display("FAIL rstmid_rerun_count got=%0d exp=4", rd_log.size()); end
    else for (int i = 0; i < 4; i++)
      if (rd_log[i] !== 10'(10'h100 + i)) begin failures++; $display("FAIL rstmid_rerun_addr[%0d] got=%h exp=%h", i, rd_log[i], 10'h100 + i); end
    checks++; if (bus.read_misses !== 4'd1 || to) begin failures++; $display("FAIL rstmid_rerun_misses got=%0d exp=1", bus.read_misses); end
  endtask

  // 0x100 is resident: read would be a zero-wait hit, write goes to memory.
  task automatic test_rd_wr_priority();
    int st; bit to;
    lat = 3;
    cpu_op(1'b1, 1'b1, 10'h100, st, to);
    checks++; if (wr_log.size() != 1 || rd_log.size() != 0) begin failures++; $display("FAIL prio_mem got wr=%0d rd=%0d exp 1/0", wr_log.size(), rd_log.size()); end
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL prio_we_count got=%0d exp=1", we_log.size()); end
    else if (we_log[0].sel !== 1'b0) begin failures++; $display("FAIL prio_sel got=%b exp=0", we_log[0].sel); end
    checks++; if (st != lat || to) begin failures++; $display("FAIL prio_stall got=%0d exp=%0d", st, lat); end
    checks++; if (bus.read_hits !== 4'd0 || bus.read_misses !== 4'd1) begin failures++; $display("FAIL prio_counters got hits=%0d misses=%0d exp 0/1", bus.read_hits, bus.read_misses); end
  endtask

  task automatic test_random();
    int st; bit to; bit is_wr; bit exp_hit; int exp_st;
    logic [9:0] addr; logic [2:0] tg; logic [4:0] idx; logic [9:0] base;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      lat   = $urandom_range(1, 4);
      addr  = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      is_wr = ($urandom_range(0, 9) < 3);
      tg = addr[9:7]; idx = addr[6:2]; base = {tg, idx, 2'b00};
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
      cpu_op(!is_wr, is_wr, addr, st, to);
      checks++; if (to) begin failures++; $display("FAIL rand_timeout op=%0d addr=%h", n, addr); end
      if (is_wr) begin
        exp_st = lat;
        checks++;
        if (wr_log.size() != 1 || rd_log.size() != 0) begin failures++; $display("FAIL rand_wr_mem op=%0d got wr=%0d rd=%0d exp 1/0", n, wr_log.size(), rd_log.size()); end
        else if (wr_log[0] !== addr) begin failures++; $display("FAIL rand_wr_addr op=%0d got=%h exp=%h", n, wr_log[0], addr); end
        checks++;
        if (we_log.size() != (exp_hit ? 1 : 0)) begin failures++; $display("FAIL rand_wr_we op=%0d got=%0d exp=%0d", n, we_log.size(), exp_hit); end
        else if (exp_hit && we_log[0] !== {addr[1:0], idx, tg, 1'b1, 1'b0}) begin failures++; $display("FAIL rand_wr_we_fields op=%0d got=%h exp=%h", n, we_log[0], {addr[1:0], idx, tg, 1'b1, 1'b0}); end
      end else if (exp_hit) begin
        exp_st = 0;
        if (ref_hits < CNT_MAX) ref_hits++;
        checks++;
        if (rd_log.size() != 0 || we_log.size() != 0) begin failures++; $display("FAIL rand_hit_traffic op=%0d got rd=%0d we=%0d exp 0/0", n, rd_log.size(), we_log.size()); end
      end else begin
        exp_st = 4 * lat + 4;
        if (ref_misses < CNT_MAX) ref_misses++;
        ref_valid[idx] = 1'b1; ref_tag[idx] = tg;
        checks++;
        if (rd_log.size() != 4 || we_log.size() != 4) begin failures++; $display("FAIL rand_refill_count op=%0d got rd=%0d we=%0d exp 4/4", n, rd_log.size(), we_log.size()); end
        else for (int i = 0; i < 4; i++)
          if (rd_log[i] !== 10'(base + i) || we_log[i] !== {2'(i), idx, tg, 1'b1, 1'b1}) begin
            failures++; $display("FAIL rand_refill_word op=%0d w=%0d got addr=%h we=%h exp addr=%h", n, i, rd_log[i], we_log[i], base + i);
          end
      end
      checks++; if (st != exp_st) begin failures++; $display("FAIL rand_stall op=%0d got=%0d exp=%0d", n, st, exp_st); end
      checks++; if (bus.read_hits !== CNT_W'(ref_hits) || bus.read_misses !== CNT_W'(ref_misses)) begin
        failures++; $display("FAIL rand_counters op=%0d got hits=%0d misses=%0d exp %0d/%0d", n, bus.read_hits, bus.read_misses, ref_hits, ref_misses);
      end
    end
    checks++; if (we_orphan != 0) begin failures++; $display("FAIL cache_we_without_ready got=%0d exp=0", we_orphan); end
  endtask

  task automatic test_saturation();
    int st; bit to; int exp_h;
    apply_reset();
    lat = 1;
    cpu_op(1'b1, 1'b0, 10'h100, st, to);
    for (int k = 1; k <= 18; k++) begin
      cpu_op(1'b1, 1'b0, 10'(10'h100 + (k % 4)), st, to);
      exp_h = (k < CNT_MAX) ? k : CNT_MAX;
      checks++; if (bus.read_hits !== CNT_W'(exp_h) || to) begin failures++; $display("FAIL sat_hits k=%0d got=%0d exp=%0d", k, bus.read_hits, exp_h); end
    end
    checks++; if (bus.read_misses !== 4'd1) begin failures++; $display("FAIL sat_misses got=%0d exp=1", bus.read_misses); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_addr = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    ref_clear();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_refill();
    test_rd_wr_priority();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped cache controller that sits directly upstream of `cache_memory` and between the CPU load/store port and main memory. It decodes the CPU word address into tag/index/offset, detects hits from the cache's `out_tag`/`out_valid`, stalls the CPU on misses, refills a 4-word block from main memory word by word, and drives the cache's write port. The policy is write-through, no-write-allocate.

## Interface
Parameters:
- `TAG_W`, default 3: tag width; matches the `cache_memory` tag.
- `INDEX_W`, default 5: block-number width (32 blocks).
- `OFFSET_W`, default 2: word-in-block offset width (4 words per block).
- `CNT_W`, default 16: width of the performance counters.

Ports (ADDR_W = TAG_W+INDEX_W+OFFSET_W = 10). Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `cpu_addr` in ADDR_W: word address; tag = [9:7], index = [6:2], offset = [1:0].
- `cpu_rd` in 1: read request, held until `stall` is low.
- `cpu_wr` in 1: write request, held until `stall` is low.
- `stall` out 1: CPU must hold its request and address.
- `mem_rd` out 1: main-memory word read request.
- `mem_wr` out 1: main-memory word write request.
- `mem_addr` out ADDR_W: main-memory word address.
- `mem_ready` in 1: one-cycle pulse; read data is valid, or the write has completed.
- `cache_block_num` out INDEX_W: to `cache_memory.block_num`.
- `cache_byte_offset` out OFFSET_W: to `cache_memory.byte_offset`.
- `cache_tag` out TAG_W: to `cache_memory.in_tag`.
- `cache_valid` out 1: to `cache_memory.in_valid`.
- `cache_we` out 1: to `cache_memory.WE`.
- `cache_data_sel` out 1: cache `data_in` mux select; 0 = CPU write data, 1 = memory read data.
- `cache_out_tag` in TAG_W: from `cache_memory.out_tag`.
- `cache_out_valid` in 1: from `cache_memory.out_valid`.
- `read_hits` out CNT_W: saturating count of read hits.
- `read_misses` out CNT_W: saturating count of read misses.

## Operation
- `hit` = `cache_out_valid` && (`cache_out_tag` == address tag). The cache read path is combinational.
- States: IDLE, REFILL, WRITE. The request address is latched into `req_addr` on leaving IDLE. The refill word counter `cnt` is 2 bits.
- Cache address outputs:
  - In IDLE they come from `cpu_addr`.
  - In REFILL they are {`req_addr` index, `cnt`}.
  - In WRITE they come from `req_addr`.
  - `cache_tag` = request tag and `cache_valid` = 1 always.
- IDLE:
  - `cpu_wr` has priority over `cpu_rd`.
  - `cpu_wr` → WRITE, `stall` = 1.
  - `cpu_rd` with hit → stay in IDLE, `stall` = 0, `read_hits`++.
  - `cpu_rd` with miss → REFILL, `stall` = 1, `cnt` = 0, `read_misses`++.
  - No request → `stall` = 0.
- REFILL:
  - Drives `mem_rd` = 1, `mem_addr` = {tag, index, `cnt`}, `stall` = 1.
  - On `mem_ready`: `cache_we` = 1, `cache_data_sel` = 1, byte offset = `cnt`, then `cnt`++.
  - On `mem_ready` with `cnt` == 3 → IDLE. The re-evaluated read then hits and is not counted again.
- WRITE:
  - Drives `mem_wr` = 1, `mem_addr` = `req_addr`, `stall` = !`mem_ready`.
  - The hit flag is latched on IDLE exit.
  - On `mem_ready`: if the latched hit is set, `cache_we` = 1 with `cache_data_sel` = 0; go to IDLE.
  - A write miss never writes the cache.
- Counters saturate at all-ones; they do not wrap.
- `mem_ready` outside REFILL/WRITE is ignored.

## Timing
- Reset values: state IDLE, `cnt` = 0, `req_addr` = 0, counters = 0, `mem_rd` = `mem_wr` = `cache_we` = 0.
- With no request during reset, `stall` = 0.
- Read hit: zero wait states; data is available in the same cycle.
- Read miss: occupies 4 `mem_ready` pulses in REFILL. `stall` drops in the first IDLE cycle after the 4th pulse.
- Write: `stall` stays high until the `mem_ready` cycle, in which `stall` = 0. The CPU advances on that edge.
- `cache_we` is a single-cycle pulse, coincident with `mem_ready` only.
- `RST` mid-REFILL or mid-WRITE:
  - Forces IDLE and deasserts memory requests immediately.
  - Partially refilled words stay in the cache; they are not invalidated by this block.
  - A repeated request restarts from offset 0.

## Test plan
- Reset, then read 0x100 into an empty cache, with memory answering after 3 cycles → `mem_rd` at 0x100..0x103; 4 `cache_we` pulses, offsets 0..3, tag 2, valid 1; `stall` falls afterwards; `read_misses` = 1, `read_hits` = 0.
- Then read 0x102 → `stall` = 0 in the same cycle, no `mem_rd`, `read_hits` = 1.
- Write 0x101 (hit) → `mem_wr` at 0x101, `stall` high until `mem_ready`, one `cache_we` with `cache_data_sel` = 0, offset 1.
- Write 0x300 (miss, tag 6) → `mem_wr` at 0x300, `cache_we` never asserted, `read_*` counters unchanged.
- Read 0x180 (tag 3, index 0, conflicting with tag 2) → full refill at 0x180..0x183 with `cache_tag` = 3; a following read of 0x100 misses.
- Assert `RST` after the 2nd refill `mem_ready` → `mem_rd` = 0 and state IDLE immediately; re-request 0x100 → refill restarts at 0x100; simultaneous `cpu_rd` + `cpu_wr` → WRITE path taken.
